sp_mc_fifo: RTL and testbench
=============================

SP_MC_FIFO -- requirements
Module: sp_mc_fifo

Interface
REQ-001 Parameter NUM_CH, default 4 (one channel per scratchpad bank), number of independent input channels; SHALL be >= 2.
REQ-002 Parameter DEPTH, default 8, entries per channel; SHALL be a power of two >= 2.
REQ-003 Parameter DATA_W, default 102 (addr 32 + mat_s 4 + row_s 2 + row data 64), payload width.
REQ-004 Parameter AF_LVL, default DEPTH-2, almost-full occupancy threshold.
REQ-005 Port CLK input 1: single clock; all state SHALL update on its rising edge.
REQ-006 Port nRST input 1: asynchronous, active-low reset.
REQ-007 Port push input NUM_CH: per-channel write strobe.
REQ-008 Port wdata input NUM_CH*DATA_W: per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Port full output NUM_CH: channel occupancy == DEPTH.
REQ-010 Port almost_full output NUM_CH: channel occupancy >= AF_LVL.
REQ-011 Port count output NUM_CH*(log2(DEPTH)+1): per-channel occupancy.
REQ-012 Port flush input 1: synchronous clear of all channels.
REQ-013 Port out_valid output 1: a granted head entry is presented.
REQ-014 Port out_data output DATA_W: head payload of the granted channel.
REQ-015 Port out_ch output log2(NUM_CH): index of the granted channel.
REQ-016 Port out_ready input 1: consumer accepts; a pop occurs when out_valid && out_ready.
REQ-017 Port ovf_err output NUM_CH: sticky per-channel overflow flag.

Function
REQ-018 Each channel SHALL be a circular buffer with read and write pointers that wrap modulo DEPTH, plus an occupancy counter.
REQ-019 A push to a channel whose registered count < DEPTH SHALL be written at the write pointer and be eligible for output on the next cycle.
REQ-020 A push to a full channel SHALL be dropped even if that channel pops in the same cycle, and SHALL set that channel's ovf_err bit.
REQ-021 A simultaneous accepted push and pop on one channel SHALL leave its count unchanged.
REQ-022 out_valid SHALL be 1 whenever any channel has count > 0; out_data and out_ch SHALL be combinational from the head of the granted channel.
REQ-023 Arbitration: the grant SHALL go to the first non-empty channel at or after rr_ptr (wrapping); after a pop, rr_ptr SHALL become (granted + 1) mod NUM_CH.
REQ-024 Lock: while out_valid && !out_ready, the grant SHALL be held in a lock register, so out_ch and out_data stay stable until the pop regardless of new pushes.
REQ-025 The lock SHALL release on the pop cycle; the next grant SHALL be recomputed on the following cycle.
REQ-026 flush SHALL, on the next edge, zero all pointers and counts, clear the lock, set rr_ptr to 0 and clear ovf_err.
REQ-027 A push or pop in the same cycle as flush SHALL have no effect.
REQ-028 full, almost_full and count SHALL be decoded from registered counters only.

Reset
REQ-029 On nRST low, immediately and independent of CLK: all pointers, counts and ovf_err SHALL be 0, rr_ptr 0, lock clear, out_valid 0, full 0, almost_full 0 (AF_LVL > 0).
REQ-030 A reset asserted mid-transfer SHALL discard all stored entries; storage contents need not be cleared.

Configuration
REQ-031 With macro SP_MC_FIFO_STRICT_PRIO_EN defined, the grant SHALL be the lowest-index non-empty channel and rr_ptr SHALL be absent; without it, round-robin per REQ-023 applies. The lock (REQ-024) SHALL apply in both modes.

Verification
REQ-032 Push 0xA1 on ch2 at cycle 0 -> out_valid=1, out_ch=2, out_data=0xA1 at cycle 1; pop -> count[2]=0, out_valid=0 at cycle 2.
REQ-033 Push 9 entries into ch0 with out_ready=0 -> full[0]=1 after 8 pushes, almost_full[0]=1 from count 6, 9th push dropped, ovf_err[0]=1, the 8 entries drain in order.
REQ-034 Preload ch0..ch3 with 2 entries each, hold out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3 (round-robin); with SP_MC_FIFO_STRICT_PRIO_EN -> 0,0,1,1,2,2,3,3.
REQ-035 Ch3 presented, out_ready=0 for 5 cycles while ch0 receives pushes -> out_ch stays 3 and out_data stays unchanged until the pop.
REQ-036 Ch1 full, push and pop on ch1 in the same cycle -> push dropped, count[1]=7, ovf_err[1]=1; then flush asserted together with a push -> all counts 0, ovf_err=0, out_valid=0.
REQ-037 nRST asserted asynchronously between edges with 3 entries queued -> out_valid and count drop to 0 before the next edge, and no entry reappears after release.

Source files
------------

// File: rtl/sp_mc_fifo.sv
// sp_mc_fifo: per-channel circular FIFOs merged onto one output by a locking arbiter.
// Define SP_MC_FIFO_STRICT_PRIO_EN for lowest-index-first priority instead of round-robin.
module sp_mc_fifo #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 102,
    parameter int AF_LVL = DEPTH - 2
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic [NUM_CH-1:0]                   push,
    input  logic [NUM_CH*DATA_W-1:0]            wdata,
    output logic [NUM_CH-1:0]                   full,
    output logic [NUM_CH-1:0]                   almost_full,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] count,
    input  logic                                flush,
    output logic                                out_valid,
    output logic [DATA_W-1:0]                   out_data,
    output logic [$clog2(NUM_CH)-1:0]           out_ch,
    input  logic                                out_ready,
    output logic [NUM_CH-1:0]                   ovf_err
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CHW = $clog2(NUM_CH);
    localparam int JW  = CHW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);

    logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
    logic [AW-1:0]     wp  [NUM_CH];
    logic [AW-1:0]     rp  [NUM_CH];
    logic [CW-1:0]     cnt [NUM_CH];
    logic [NUM_CH-1:0] nonempty, acc, ovf_set, pop_v;
    logic              pop, lock_vld;
    logic [CHW-1:0]    lock_ch, arb_ch;

    // Status from registered counters; a push is accepted only if the pre-edge count is below DEPTH
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i]       = cnt[i] != '0;
            full[i]           = cnt[i] == FULL_C;
            almost_full[i]    = cnt[i] >= AF_C;
            count[i*CW +: CW] = cnt[i];
            acc[i]            = push[i] && !full[i] && !flush;
            ovf_set[i]        = push[i] && full[i] && !flush;
        end
    end

`ifdef SP_MC_FIFO_STRICT_PRIO_EN
    // Lowest-index non-empty channel wins
    always_comb begin
        arb_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (nonempty[k]) arb_ch = CHW'(k);
    end
`else
    logic [CHW-1:0] rr_ptr;
    logic [JW-1:0]  j;

    // First non-empty channel at or after rr_ptr, wrapping; scanning downward lets the nearest win
    always_comb begin
        arb_ch = '0;
        j      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = JW'(rr_ptr) + JW'(k);
            if (j >= JW'(NUM_CH)) j = j - JW'(NUM_CH);
            if (nonempty[j[CHW-1:0]]) arb_ch = j[CHW-1:0];
        end
    end

    // Round-robin pointer moves just past the channel that was popped
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) rr_ptr <= '0;
        else if (flush) rr_ptr <= '0;
        else if (pop) rr_ptr <= (out_ch == CHW'(NUM_CH - 1)) ? '0 : out_ch + CHW'(1);
    end
`endif

    // A held grant overrides the live arbiter so the presented entry cannot change under a stall
    always_comb begin
        out_valid = |nonempty;
        out_ch    = lock_vld ? lock_ch : arb_ch;
        out_data  = mem[out_ch][rp[out_ch]];
        pop       = out_valid && out_ready && !flush;
        for (int i = 0; i < NUM_CH; i++) pop_v[i] = pop && out_ch == CHW'(i);
    end

    // Pointers, occupancy, sticky overflow and grant lock
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            ovf_err  <= '0;
            lock_vld <= 1'b0;
            lock_ch  <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            ovf_err  <= '0;
            lock_vld <= 1'b0;
            lock_ch  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[i]) wp[i] <= wp[i] + AW'(1);
                if (pop_v[i]) rp[i] <= rp[i] + AW'(1);
                cnt[i] <= cnt[i] + CW'(acc[i]) - CW'(pop_v[i]);
            end
            ovf_err  <= ovf_err | ovf_set;
            lock_vld <= out_valid && !out_ready;
            lock_ch  <= out_ch;
        end
    end

    // Payload storage; contents are left as-is on reset and flush
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CH; i++)
            if (acc[i]) mem[i][wp[i]] <= wdata[i*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_sp_mc_fifo.sv
// tb_sp_mc_fifo: vector table plus corner sequences, with per-channel scoreboard queues.
module tb_sp_mc_fifo;
    localparam int NC = 4;
    localparam int DP = 8;
    localparam int DW = 102;
    localparam int CW = 4;

    logic             CLK = 1'b0;
    logic             nRST = 1'b1;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [NC-1:0]    push = '0;
    logic [NC-1:0]    full, almost_full, ovf_err;
    logic [NC*DW-1:0] wdata = '0;
    logic [NC*CW-1:0] count;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_ch;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] sb [NC][$];
    logic [NC-1:0] xovf = '0;

    typedef struct {
        logic [3:0] p;
        logic [7:0] d;
        logic       rdy;
        logic       fl;
        logic       ev;
        logic [1:0] ech;
        logic [7:0] ed;
    } vec_t;
    vec_t tv [11];

    sp_mc_fifo #(.NUM_CH(NC), .DEPTH(DP), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST), .push(push), .wdata(wdata), .full(full),
        .almost_full(almost_full), .count(count), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready), .ovf_err(ovf_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic put(input int c, input logic [DW-1:0] v);
        push[c] = 1'b1;
        wdata[c*DW +: DW] = v;
    endtask

    // One clock: update scoreboard from driven inputs, take the edge, check status against it
    task automatic tick();
        logic [NC-1:0] acc, xv, xf, xa;
        logic [DW-1:0] e;
        for (int i = 0; i < NC; i++) begin
            acc[i] = push[i] && !flush && sb[i].size() < DP;
            if (push[i] && !flush && sb[i].size() == DP) xovf[i] = 1'b1;
        end
        if (!flush && out_valid === 1'b1 && out_ready) begin
            n_chk++;
            if (sb[out_ch].size() == 0) begin
                n_fail++;
                $display("FAIL pop_empty: got pop on ch%0d required no entry there", out_ch);
            end else begin
                e = sb[out_ch].pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", out_data, e);
                end
            end
        end
        for (int i = 0; i < NC; i++)
            if (acc[i]) sb[i].push_back(wdata[i*DW +: DW]);
        if (flush) begin
            for (int i = 0; i < NC; i++) sb[i].delete();
            xovf = '0;
        end
        @(posedge CLK);
        #1;
        push  = '0;
        flush = 1'b0;
        for (int i = 0; i < NC; i++) begin
            xv[i] = sb[i].size() != 0;
            xf[i] = sb[i].size() == DP;
            xa[i] = sb[i].size() >= DP - 2;
            chk($sformatf("count%0d", i), 128'(count[i*CW +: CW]), 128'(sb[i].size()));
        end
        chk("out_valid", 128'(out_valid), 128'(|xv));
        chk("full", 128'(full), 128'(xf));
        chk("almost_full", 128'(almost_full), 128'(xa));
        chk("ovf_err", 128'(ovf_err), 128'(xovf));
    endtask

    initial begin
        logic [1:0] es;
        tv[0]  = '{4'b0100, 8'h9F, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tv[1]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 8'hA1};
        tv[2]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tv[3]  = '{4'b0011, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tv[4]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 8'h10};
        tv[5]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h11};
        tv[6]  = '{4'b1010, 8'h10, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
`ifdef SP_MC_FIFO_STRICT_PRIO_EN
        tv[7]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h11};
        tv[8]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 8'h13};
`else
        tv[7]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 8'h13};
        tv[8]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 8'h11};
`endif
        tv[9]  = '{4'b0001, 8'h55, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
        tv[10] = '{4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

        #1 nRST = 1'b0;
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_af", 128'(almost_full), 128'(0));
        chk("rst_ovf", 128'(ovf_err), 128'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int r = 0; r < 11; r++) begin
            out_ready = tv[r].rdy;
            flush     = tv[r].fl;
            for (int c = 0; c < NC; c++)
                if (tv[r].p[c]) put(c, DW'(tv[r].d + c));
            chk($sformatf("v%0d_valid", r), 128'(out_valid), 128'(tv[r].ev));
            if (tv[r].ev) begin
                chk($sformatf("v%0d_ch", r), 128'(out_ch), 128'(tv[r].ech));
                chk($sformatf("v%0d_data", r), 128'(out_data), 128'(tv[r].ed));
            end
            tick();
        end

        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            put(0, DW'(12'h100 + k));
            tick();
        end
        chk("fill_full0", 128'(full[0]), 128'(1));
        chk("fill_ovf0", 128'(ovf_err[0]), 128'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_ch", 128'(out_ch), 128'(0));
            tick();
        end
        out_ready = 1'b0;
        flush = 1'b1;
        tick();

        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NC; c++) put(c, DW'(12'h200 + c * 16 + k));
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
`ifdef SP_MC_FIFO_STRICT_PRIO_EN
            es = 2'(k / 2);
`else
            es = 2'(k % 4);
`endif
            chk($sformatf("arb%0d", k), 128'(out_ch), 128'(es));
            tick();
        end

        out_ready = 1'b0;
        put(3, DW'(12'h333));
        tick();
        for (int k = 0; k < 5; k++) begin
            put(0, DW'(12'h400 + k));
            chk("stall_ch", 128'(out_ch), 128'(3));
            chk("stall_data", 128'(out_data), 128'(12'h333));
            tick();
        end
        out_ready = 1'b1;
        chk("release_ch", 128'(out_ch), 128'(3));
        tick();
        repeat (5) tick();

        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            put(1, DW'(12'h500 + k));
            tick();
        end
        put(1, DW'(12'h5FF));
        out_ready = 1'b1;
        chk("fullpop_ch", 128'(out_ch), 128'(1));
        tick();
        chk("fullpop_cnt1", 128'(count[7:4]), 128'(7));
        chk("fullpop_ovf1", 128'(ovf_err[1]), 128'(1));
        flush = 1'b1;
        put(2, DW'(12'h666));
        tick();
        out_ready = 1'b0;

        put(0, DW'(12'h700));
        put(1, DW'(12'h701));
        put(2, DW'(12'h702));
        tick();
        #3 nRST = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_count", 128'(count), 128'(0));
        for (int i = 0; i < NC; i++) sb[i].delete();
        xovf = '0;
        #2 nRST = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
